// File: rtl/hamming74_codec_if.sv
// Hamming(7,4) codec port bundle: encoder, decoder and counter signals.
// The master drives requests; the slave returns registered results.
interface hamming74_codec_if;
  logic       enc_ena;
  logic [3:0] enc_data_in;
  logic [6:0] enc_code_out;
  logic       enc_valid_out;

  logic       dec_ena;
  logic [6:0] dec_code_in;
  logic [3:0] dec_data_out;
  logic [2:0] dec_syndrome_out;
  logic       dec_valid_out;
  logic [2:0] dec_err_count_out;

  logic       cnt_ena;
  logic [2:0] cnt_count;
  logic       cnt_done;

  modport master (
    output enc_ena,
    output enc_data_in,
    input  enc_code_out,
    input  enc_valid_out,
    output dec_ena,
    output dec_code_in,
    input  dec_data_out,
    input  dec_syndrome_out,
    input  dec_valid_out,
    input  dec_err_count_out,
    output cnt_ena,
    input  cnt_count,
    input  cnt_done
  );

  modport slave (
    input  enc_ena,
    input  enc_data_in,
    output enc_code_out,
    output enc_valid_out,
    input  dec_ena,
    input  dec_code_in,
    output dec_data_out,
    output dec_syndrome_out,
    output dec_valid_out,
    output dec_err_count_out,
    input  cnt_ena,
    output cnt_count,
    output cnt_done
  );
endinterface

// File: rtl/hamming74_codec.sv
// Hamming(7,4) encoder, single-error-correcting decoder
// with error counter, plus an independent 3-bit counter.
module hamming74_codec (
  input  logic             clk,
  input  logic             rst_n,
  hamming74_codec_if.slave io
);

  // Codeword bit i is 1-based position i+1; parity sits at 1,2,4.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1;
    logic p2;
    logic p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  function automatic logic [2:0] syndrome(input logic [6:0] c);
    logic s1;
    logic s2;
    logic s4;
    s1 = c[0] ^ c[2] ^ c[4] ^ c[6];
    s2 = c[1] ^ c[2] ^ c[5] ^ c[6];
    s4 = c[3] ^ c[4] ^ c[5] ^ c[6];
    return {s4, s2, s1};
  endfunction

  logic [6:0] enc_code;
  logic       enc_valid;
  logic [3:0] dec_data;
  logic [2:0] dec_syn;
  logic       dec_valid;
  logic [2:0] dec_errs;
  logic [2:0] cnt;

  logic [2:0] syn;
  logic [6:0] flip;
  logic [6:0] fixed;

  // Syndrome value S names the 1-based position to invert.
  always_comb begin
    syn   = syndrome(io.dec_code_in);
    flip  = '0;
    if (syn != 3'd0)
      flip = 7'd1 << (syn - 3'd1);
    fixed = io.dec_code_in ^ flip;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_code  <= '0;
      enc_valid <= 1'b0;
    end else begin
      enc_valid <= io.enc_ena;
      if (io.enc_ena)
        enc_code <= encode(io.enc_data_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_data  <= '0;
      dec_syn   <= '0;
      dec_valid <= 1'b0;
      dec_errs  <= '0;
    end else begin
      dec_valid <= io.dec_ena;
      if (io.dec_ena) begin
        dec_data <= {fixed[6], fixed[5], fixed[4], fixed[2]};
        dec_syn  <= syn;
        if (syn != 3'd0)
          dec_errs <= dec_errs + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (io.cnt_ena)
      cnt <= cnt + 3'd1;
  end

  assign io.enc_code_out      = enc_code;
  assign io.enc_valid_out     = enc_valid;
  assign io.dec_data_out      = dec_data;
  assign io.dec_syndrome_out  = dec_syn;
  assign io.dec_valid_out     = dec_valid;
  assign io.dec_err_count_out = dec_errs;
  assign io.cnt_count         = cnt;
  assign io.cnt_done          = (cnt == 3'd7);

endmodule

// File: tb/tb_hamming74_codec.sv
// Scoreboard bench for hamming74_codec: per-cycle expectations
// from a positional Hamming model, checked by a separate monitor.
module tb_hamming74_codec;

  logic clk;
  logic rst_n;

  hamming74_codec_if io ();

  hamming74_codec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       enc_v;
    logic [6:0] enc_code;
    logic       dec_v;
    logic [3:0] dec_data;
    logic [2:0] dec_syn;
    logic [2:0] dec_errs;
    logic [2:0] cnt;
  } exp_t;

  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;

  logic       m_encv;
  logic [6:0] m_code;
  logic       m_decv;
  logic [3:0] m_data;
  logic [2:0] m_syn;
  logic [2:0] m_errs;
  logic [2:0] m_cnt;

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endfunction

  // Reference: place data at positions 3,5,6,7; each parity position p
  // covers every other position whose index has bit p set.
  function automatic logic [6:0] ref_enc(input logic [3:0] d);
    int dpos[4];
    logic [7:1] w;
    logic par;
    dpos = '{3, 5, 6, 7};
    w = '0;
    for (int i = 0; i < 4; i++) w[dpos[i]] = d[i];
    for (int p = 1; p <= 4; p = p * 2) begin
      par = 1'b0;
      for (int k = 1; k <= 7; k++)
        if (k != p && (k & p) != 0) par ^= w[k];
      w[p] = par;
    end
    return w[7:1];
  endfunction

  // Syndrome is the XOR of the positions of all set bits.
  task automatic ref_dec(input logic [6:0] c,
                         output logic [3:0] d,
                         output logic [2:0] s);
    logic [7:1] w;
    w = c;
    s = '0;
    for (int k = 1; k <= 7; k++)
      if (w[k]) s ^= 3'(k);
    if (s != 3'd0) w[s] = ~w[s];
    d = {w[7], w[6], w[5], w[3]};
  endtask

  function automatic void model_clear();
    m_encv = 1'b0;
    m_code = '0;
    m_decv = 1'b0;
    m_data = '0;
    m_syn  = '0;
    m_errs = '0;
    m_cnt  = '0;
  endfunction

  task automatic step(input logic ee, input logic [3:0] ed,
                      input logic de, input logic [6:0] dc,
                      input logic ce);
    exp_t e;
    logic [3:0] rd;
    logic [2:0] rs;
    @(negedge clk);
    io.enc_ena     = ee;
    io.enc_data_in = ed;
    io.dec_ena     = de;
    io.dec_code_in = dc;
    io.cnt_ena     = ce;
    m_encv = ee;
    if (ee) m_code = ref_enc(ed);
    m_decv = de;
    if (de) begin
      ref_dec(dc, rd, rs);
      m_data = rd;
      m_syn  = rs;
      if (rs != 3'd0) m_errs = m_errs + 3'd1;
    end
    if (ce) m_cnt = m_cnt + 3'd1;
    e.enc_v    = m_encv;
    e.enc_code = m_code;
    e.dec_v    = m_decv;
    e.dec_data = m_data;
    e.dec_syn  = m_syn;
    e.dec_errs = m_errs;
    e.cnt      = m_cnt;
    q.push_back(e);
  endtask

  task automatic idle_inputs();
    io.enc_ena     = 1'b0;
    io.enc_data_in = '0;
    io.dec_ena     = 1'b0;
    io.dec_code_in = '0;
    io.cnt_ena     = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_enc_code"}, 32'(io.enc_code_out), 0);
    chk({tag, "_enc_v"},    32'(io.enc_valid_out), 0);
    chk({tag, "_dec_data"}, 32'(io.dec_data_out), 0);
    chk({tag, "_dec_syn"},  32'(io.dec_syndrome_out), 0);
    chk({tag, "_dec_v"},    32'(io.dec_valid_out), 0);
    chk({tag, "_dec_errs"}, 32'(io.dec_err_count_out), 0);
    chk({tag, "_cnt"},      32'(io.cnt_count), 0);
    chk({tag, "_cnt_done"}, 32'(io.cnt_done), 0);
  endtask

  // Abort whatever was issued at the last negedge, before its edge.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check_zero("rst_mid");
    q.delete();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      chk("enc_valid", 32'(io.enc_valid_out), 32'(e.enc_v));
      chk("enc_code",  32'(io.enc_code_out),  32'(e.enc_code));
      chk("dec_valid", 32'(io.dec_valid_out), 32'(e.dec_v));
      chk("dec_data",  32'(io.dec_data_out),  32'(e.dec_data));
      chk("dec_syn",   32'(io.dec_syndrome_out), 32'(e.dec_syn));
      chk("dec_errs",  32'(io.dec_err_count_out), 32'(e.dec_errs));
      chk("cnt",       32'(io.cnt_count), 32'(e.cnt));
      chk("cnt_done",  32'(io.cnt_done), 32'(e.cnt == 3'd7));
    end
  end

  initial begin
    logic [6:0] c;
    logic [3:0] d;
    rst_n = 1'b0;
    idle_inputs();
    model_clear();
    #3;
    check_zero("rst_init");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Counter from reset: 1..7,0,1 with done only at 7.
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 1);

    // Directed encode/decode with fixed expected codewords.
    step(1, 4'hB, 0, 0, 0);
    @(posedge clk); #2;
    chk("dir_enc_B", 32'(io.enc_code_out), 32'h55);
    step(1, 4'h1, 0, 0, 0);
    @(posedge clk); #2;
    chk("dir_enc_1", 32'(io.enc_code_out), 32'h07);
    step(1, 4'hF, 0, 0, 0);
    @(posedge clk); #2;
    chk("dir_enc_F", 32'(io.enc_code_out), 32'h7F);
    step(1, 4'h0, 0, 0, 0);
    @(posedge clk); #2;
    chk("dir_enc_0", 32'(io.enc_code_out), 32'h00);
    step(0, 0, 1, 7'h55, 0);
    @(posedge clk); #2;
    chk("dir_dec_55", 32'(io.dec_data_out), 32'hB);
    chk("dir_syn_55", 32'(io.dec_syndrome_out), 0);
    step(0, 0, 1, 7'h45, 0);
    @(posedge clk); #2;
    chk("dir_dec_45", 32'(io.dec_data_out), 32'hB);
    chk("dir_syn_45", 32'(io.dec_syndrome_out), 5);
    chk("dir_errs_45", 32'(io.dec_err_count_out), 1);
    step(0, 0, 0, 0, 0);

    // Every nibble with no error and each single-bit error.
    for (int n = 0; n < 16; n++)
      for (int e = 0; e < 8; e++) begin
        c = ref_enc(4'(n));
        if (e != 0) c[e - 1] = ~c[e - 1];
        step(0, 0, 1, c, 0);
      end

    step(1, 4'h6, 1, 7'h2A, 1);
    mid_reset();

    // Eight corrupted decodes wrap the error count back to zero.
    for (int i = 0; i < 8; i++) begin
      c = ref_enc(4'($urandom_range(15)));
      c[i % 7] = ~c[i % 7];
      step(0, 0, 1, c, 0);
    end
    @(posedge clk); #2;
    chk("errs_wrap", 32'(io.dec_err_count_out), 0);
    for (int i = 0; i < 3; i++) step(1, 4'(i), 1, 7'h01, 1);
    mid_reset();

    // Random mix: all units concurrently, some double errors.
    for (int i = 0; i < 400; i++) begin
      d = 4'($urandom_range(15));
      case ($urandom_range(2))
        0: c = ref_enc(d);
        1: begin
          c = ref_enc(d);
          c[$urandom_range(6)] ^= 1'b1;
        end
        default: c = 7'($urandom_range(127));
      endcase
      step(1'($urandom_range(1)), 4'($urandom_range(15)),
           1'($urandom_range(1)), c, 1'($urandom_range(1)));
    end
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("drain", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hamming74_codec.md
HAMMING74_CODEC -- requirements
Module: hamming74_codec

Interface
REQ-001 Reset rst_n, asynchronous, active-low; clock clk; all state on rising clk edge.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 enc_ena  input  1  encode request, sampled each clk edge.
REQ-005 enc_data_in  input  4  data nibble {d3,d2,d1,d0}.
REQ-006 enc_code_out  output  7  registered Hamming(7,4) codeword.
REQ-007 enc_valid_out  output  1  one-cycle pulse, codeword updated.
REQ-008 dec_ena  input  1  decode request, sampled each clk edge.
REQ-009 dec_code_in  input  7  received codeword, possibly with one bit in error.
REQ-010 dec_data_out  output  4  registered corrected data nibble.
REQ-011 dec_syndrome_out  output  3  registered syndrome of last decode.
REQ-012 dec_valid_out  output  1  one-cycle pulse, decode results updated.
REQ-013 dec_err_count_out  output  3  count of decodes with nonzero syndrome.
REQ-014 cnt_ena  input  1  free-running counter enable.
REQ-015 cnt_count  output  3  free-running counter value.
REQ-016 cnt_done  output  1  high while cnt_count == 7.

Function
REQ-017 Codeword bit i holds 1-based position i+1: bit0=p1, bit1=p2, bit2=d0, bit3=p4, bit4=d1, bit5=d2, bit6=d3.
REQ-018 Parity: p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3 (even parity).
REQ-019 Encoder: on edge with enc_ena=1, enc_code_out <= codeword(enc_data_in), enc_valid_out <= 1; latency one cycle.
REQ-020 Encoder: on edge with enc_ena=0, enc_valid_out <= 0, enc_code_out holds.
REQ-021 enc_ena held high re-encodes every cycle; enc_valid_out stays high while enc_ena high.
REQ-022 Syndrome {s4,s2,s1}: s1=c0^c2^c4^c6, s2=c1^c2^c5^c6, s4=c3^c4^c5^c6.
REQ-023 Nonzero syndrome S means bit S-1 is inverted before data extraction; S=0 means no correction.
REQ-024 Decoder: on edge with dec_ena=1, dec_data_out <= {c6,c5,c4,c2} of corrected word, dec_syndrome_out <= S, dec_valid_out <= 1; latency one cycle.
REQ-025 Decoder: on edge with dec_ena=1 and S!=0, dec_err_count_out increments, wrapping 7->0.
REQ-026 Decoder: on edge with dec_ena=0, dec_valid_out <= 0; dec_data_out, dec_syndrome_out, dec_err_count_out hold.
REQ-027 Double-bit errors are not detected; decoder applies single-bit correction by syndrome regardless.
REQ-028 Counter: on edge with cnt_ena=1, cnt_count increments mod 8 (7->0); cnt_ena=0 holds.
REQ-029 cnt_done combinational: (cnt_count == 3'd7), independent of cnt_ena.
REQ-030 Encoder, decoder, counter are independent; simultaneous enables all act in same cycle.

Reset
REQ-031 rst_n low asynchronously clears enc_code_out, enc_valid_out, dec_data_out, dec_syndrome_out, dec_valid_out, dec_err_count_out, cnt_count to 0; cnt_done therefore 0.
REQ-032 Reset asserted mid-operation aborts any pending result; first edge after release behaves per inputs at that edge.

Verification
REQ-033 enc_ena pulse, data 4'hB -> next cycle enc_code_out=7'h55, enc_valid_out=1 for one cycle; data 4'h1 -> 7'h07; 4'hF -> 7'h7F; 4'h0 -> 7'h00.
REQ-034 dec_ena pulse, code 7'h55 -> dec_data_out=4'hB, dec_syndrome_out=0, dec_err_count_out unchanged.
REQ-035 dec_ena pulse, code 7'h45 (bit4 flipped) -> dec_data_out=4'hB, dec_syndrome_out=3'd5, dec_err_count_out +1.
REQ-036 Exhaustive: all 16 nibbles x 8 error patterns (none + each single bit) -> decode of encoded word returns original nibble; syndrome = flipped position.
REQ-037 cnt_ena=1 for 9 cycles from reset -> cnt_count 1..7,0,1; cnt_done high only at count 7.
REQ-038 Eight error decodes -> dec_err_count_out wraps to 0; rst_n pulse mid-sequence -> all outputs 0 immediately.
